lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial pseudo-random sequence checker that consumes the bitstream produced by the team's LFSR generators. It self-synchronises to the incoming stream, declares lock, then counts bit errors against a locally free-running copy of the same polynomial. It sits at the receive end of PRBS loopback and link-test paths.

## Interface

- WIDTH, 7, LFSR length in bits (≥ 2)
- TAPS, 7'b1100000, feedback mask; predicted bit = XOR of (history & TAPS); default is PRBS7 (x^7+x^6+1)
- SYNC_COUNT, 8, consecutive matching bits required in VERIFY before lock (≥ 1)
- LOSS_THRESH, 4, consecutive mismatches in LOCKED that drop lock (≥ 1)
- CNT_W, 16, error counter width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  1  received serial bit
- din_valid  in  1  din is sampled on this cycle's rising edge when high
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle pulse on each mismatch detected in LOCKED
- err_cnt  out  CNT_W  saturating count of mismatches seen in LOCKED

## Operation

- History register r[WIDTH-1:0]; r[0] is the most recent bit; a shift is r <= {r[WIDTH-2:0], b}.
- Prediction p = ^(r & TAPS), combinational from the current r.
- Generator convention matched: each generator step emits its feedback bit, which becomes its new LSB. The checker's r therefore mirrors the generator state once filled.
- Nothing changes on cycles with din_valid low (state, counters, r, and err_pulse = 0).
- FILL: on each valid bit, shift din into r and increment fill_cnt. When the WIDTH-th bit is taken, go to VERIFY with match_cnt = 0.
- VERIFY: on each valid bit, shift din into r.
  - din == p: match_cnt++. When match_cnt reaches SYNC_COUNT, go to LOCKED with loss_cnt = 0.
  - din != p: match_cnt = 0 and stay in VERIFY.
  - If r (before the shift) is all zeros, go to FILL with fill_cnt = 0 and ignore the bit. This rejects a stuck-zero stream.
- LOCKED: on each valid bit, shift p (not din) into r, so the reference free-runs and each line error counts exactly once.
  - din != p: err_pulse = 1, err_cnt++ (saturates at 2^CNT_W-1), loss_cnt++. When loss_cnt reaches LOSS_THRESH, go to FILL with fill_cnt = 0, and locked falls.
  - din == p: loss_cnt = 0.
- Counter clearing:
  - clr_cnt clears err_cnt in any state.
  - clr_cnt coincident with an error: clear wins and err_cnt = 0. err_pulse still fires.
  - err_cnt is not cleared by loss of lock; only rst or clr_cnt clear it.
- Reset: state = FILL, r = 0, fill_cnt = match_cnt = loss_cnt = 0, locked = 0, err_pulse = 0, err_cnt = 0. Reset mid-stream discards all history; re-lock then takes the full FILL+VERIFY sequence.

## Timing

- All outputs are registered and update on the same edge that samples the triggering valid bit.
- Lock latency with continuous valid and a clean stream: locked rises after exactly WIDTH + SYNC_COUNT valid bits (15 for defaults).
- err_pulse is high for exactly one cycle per erroneous valid bit. err_cnt reflects the increment on the same edge.
- Loss of lock: locked falls on the edge sampling the LOSS_THRESH-th consecutive error.
- Gaps in din_valid are transparent: lock and error behaviour depend only on the sequence of valid bits.

## Test plan

- Clean PRBS7 from seed 7'b1111111, din_valid continuous:
  - locked = 0 through valid bit 14, and = 1 after bit 15.
  - Running 1000 further bits gives err_cnt = 0 and err_pulse never high.
- Locked, then invert single bits at 3 isolated positions ≥ 10 bits apart:
  - exactly 3 err_pulse cycles, err_cnt = 3, locked stays 1.
- Locked, then 4 consecutive inverted bits:
  - err_cnt = 4; locked falls on the 4th.
  - The clean stream that follows re-locks after 15 further valid bits.
- All-zero input stream for 100 bits: locked never rises, err_cnt = 0.
- din_valid toggling 1-0-1-0 on a clean stream: locked after 15 valid bits, i.e. 29 cycles. Plus an error injected with clr_cnt on the same cycle: err_pulse = 1, err_cnt = 0.
- Saturation, with CNT_W = 2 and LOSS_THRESH = 8: 5 isolated errors give err_cnt = 3. rst asserted mid-lock: all outputs read 0 immediately, asynchronously.

Source files
------------

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: fills a history register from the line, verifies the
// polynomial prediction, then free-runs the reference and counts bit errors.
module lfsr_checker #(
  parameter int              WIDTH       = 7,
  parameter logic [WIDTH-1:0] TAPS       = 7'b1100000,
  parameter int              SYNC_COUNT  = 8,
  parameter int              LOSS_THRESH = 4,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(SYNC_COUNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_COUNT);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH);

  typedef enum logic [1:0] {S_FILL, S_VERIFY, S_LOCKED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, r_nxt;
  logic [FW-1:0]    fill_cnt, fill_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [LW-1:0]    loss_cnt, loss_nxt;
  logic             pred, mismatch, r_zero, err_hit;

  assign pred     = ^(r & TAPS);
  assign mismatch = din ^ pred;
  assign r_zero   = (r == '0);

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    fill_nxt  = fill_cnt;
    match_nxt = match_cnt;
    loss_nxt  = loss_cnt;
    err_hit   = 1'b0;
    if (din_valid) begin
      unique case (state)
        S_FILL: begin
          r_nxt    = {r[WIDTH-2:0], din};
          fill_nxt = fill_cnt + FW'(1);
          if (fill_nxt == FILL_LAST) begin
            state_nxt = S_VERIFY;
            fill_nxt  = '0;
            match_nxt = '0;
          end
        end
        S_VERIFY: begin
          // An all-zero history is the LFSR lock-up state: never trust it.
          if (r_zero) begin
            state_nxt = S_FILL;
            fill_nxt  = '0;
          end else begin
            r_nxt = {r[WIDTH-2:0], din};
            if (!mismatch) begin
              match_nxt = match_cnt + MW'(1);
              if (match_nxt == SYNC_LAST) begin
                state_nxt = S_LOCKED;
                loss_nxt  = '0;
              end
            end else begin
              match_nxt = '0;
            end
          end
        end
        S_LOCKED: begin
          // Reference free-runs on its own prediction so a line error is
          // counted once instead of corrupting the next WIDTH predictions.
          r_nxt = {r[WIDTH-2:0], pred};
          if (mismatch) begin
            err_hit  = 1'b1;
            loss_nxt = loss_cnt + LW'(1);
            if (loss_nxt == LOSS_LAST) begin
              state_nxt = S_FILL;
              fill_nxt  = '0;
            end
          end else begin
            loss_nxt = '0;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      loss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      r         <= r_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      loss_cnt  <= loss_nxt;
      locked    <= (state_nxt == S_LOCKED);
      err_pulse <= err_hit;
      if (clr_cnt)
        err_cnt <= '0;
      else if (err_hit && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: two instances (default and a small
// saturating counter) fed by one PRBS7 source, checked against a bit-level model.
module tb_lfsr_checker;

  localparam int             W    = 7;
  localparam logic [W-1:0]   TP   = 7'b1100000;
  localparam int             SYNC = 8;
  localparam int PH_FILL = 0, PH_VER = 1, PH_LOCK = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic din = 1'b0, din_valid = 1'b0, clr_cnt = 1'b0;
  logic locked0, pulse0, locked1, pulse1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  lfsr_checker dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0));

  lfsr_checker #(.CNT_W(2), .LOSS_THRESH(8)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1));

  int total = 0, bad = 0;
  int pulses0 = 0;

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Generator: each step emits the feedback bit, which becomes the new LSB.
  logic [W-1:0] g = 7'b1111111;
  function automatic bit gen_next();
    bit fb;
    fb = ^(g & TP);
    g  = {g[W-2:0], fb};
    return fb;
  endfunction

  // Reference model: history as a bit array, newest bit at index 0.
  bit hb[2][W];
  int ph[2], fillc[2], matchc[2], lossc[2], errs[2];
  bit pls[2];

  function automatic bit m_pred(int k);
    bit p = 0;
    logic [W-1:0] tp = TP;
    for (int i = 0; i < W; i++) if (tp[i]) p ^= hb[k][i];
    return p;
  endfunction

  function automatic void m_push(int k, bit b);
    for (int i = W - 1; i > 0; i--) hb[k][i] = hb[k][i-1];
    hb[k][0] = b;
  endfunction

  function automatic bit m_hist_zero(int k);
    for (int i = 0; i < W; i++) if (hb[k][i]) return 0;
    return 1;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W; i++) hb[k][i] = 0;
      ph[k] = PH_FILL; fillc[k] = 0; matchc[k] = 0; lossc[k] = 0;
      errs[k] = 0; pls[k] = 0;
    end
  endfunction

  function automatic void m_step(int k, bit b, bit v, bit clr, int lth, int cmax);
    bit p;
    pls[k] = 0;
    if (v) begin
      p = m_pred(k);
      if (ph[k] == PH_FILL) begin
        m_push(k, b);
        fillc[k]++;
        if (fillc[k] == W) begin ph[k] = PH_VER; matchc[k] = 0; end
      end else if (ph[k] == PH_VER) begin
        if (m_hist_zero(k)) begin
          ph[k] = PH_FILL; fillc[k] = 0;
        end else begin
          m_push(k, b);
          if (b == p) begin
            matchc[k]++;
            if (matchc[k] == SYNC) begin ph[k] = PH_LOCK; lossc[k] = 0; end
          end else matchc[k] = 0;
        end
      end else begin
        m_push(k, p);
        if (b != p) begin
          pls[k] = 1;
          if (errs[k] < cmax) errs[k]++;
          lossc[k]++;
          if (lossc[k] == lth) begin ph[k] = PH_FILL; fillc[k] = 0; end
        end else lossc[k] = 0;
      end
    end
    if (clr) errs[k] = 0;
  endfunction

  typedef struct {
    bit l0, p0, l1, p1;
    int c0, c1;
  } exp_t;
  exp_t exp_q[$];

  task automatic send_raw(bit b, bit v, bit clr);
    exp_t e;
    @(negedge clk);
    din = b; din_valid = v; clr_cnt = clr;
    m_step(0, b, v, clr, 4, 65535);
    m_step(1, b, v, clr, 8, 3);
    e.l0 = (ph[0] == PH_LOCK); e.p0 = pls[0]; e.c0 = errs[0];
    e.l1 = (ph[1] == PH_LOCK); e.p1 = pls[1]; e.c1 = errs[1];
    exp_q.push_back(e);
  endtask

  task automatic send(bit inv, bit v, bit clr);
    bit b;
    if (v) b = gen_next() ^ inv;
    else   b = 1'($urandom);
    send_raw(b, v, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    m_reset();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per driven edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_locked0", int'(locked0), int'(e.l0));
      chk("sb_pulse0",  int'(pulse0),  int'(e.p0));
      chk("sb_cnt0",    int'(cnt0),    e.c0);
      chk("sb_locked1", int'(locked1), int'(e.l1));
      chk("sb_pulse1",  int'(pulse1),  int'(e.p1));
      chk("sb_cnt1",    int'(cnt1),    e.c1);
      if (pulse0) pulses0++;
    end
  end

  initial begin
    int p_base, n, gap;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_locked", int'(locked0), 0);
    chk("rst_pulse",  int'(pulse0),  0);
    chk("rst_cnt",    int'(cnt0),    0);
    rst = 1'b0;

    // Clean stream: lock on exactly the 15th valid bit.
    for (int i = 1; i <= 15; i++) begin
      send(0, 1, 0);
      if (i >= 14) begin settle(); chk("lock_latency", int'(locked0), (i == 15) ? 1 : 0); end
    end
    p_base = pulses0;
    for (int i = 0; i < 1000; i++) send(0, 1, 0);
    settle();
    chk("clean_pulses", pulses0 - p_base, 0);
    chk("clean_cnt", int'(cnt0), 0);

    // Three isolated single-bit errors.
    p_base = pulses0;
    for (int e = 0; e < 3; e++) begin
      send(1, 1, 0);
      gap = $urandom_range(10, 20);
      for (int i = 0; i < gap; i++) send(0, 1, 0);
    end
    settle();
    chk("iso_pulses", pulses0 - p_base, 3);
    chk("iso_cnt", int'(cnt0), 3);
    chk("iso_locked", int'(locked0), 1);

    // Burst of four errors drops lock on the fourth, then full re-lock.
    send(0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      send(1, 1, 0);
      settle();
      chk("burst_locked", int'(locked0), (i == 4) ? 0 : 1);
    end
    chk("burst_cnt", int'(cnt0), 4);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      send(0, 1, 0);
      settle();
      if (locked0) begin n = i; break; end
    end
    chk("relock_bits", n, 15);

    // Stuck-zero line never locks.
    do_reset();
    for (int i = 0; i < 100; i++) send_raw(0, 1, 0);
    settle();
    chk("zero_locked", int'(locked0), 0);
    chk("zero_cnt", int'(cnt0), 0);

    // Valid toggling 1-0-1-0: 15th valid bit lands on cycle 29.
    do_reset();
    g = 7'b1111111;
    for (int c = 1; c <= 29; c++) begin
      send(0, (c % 2) == 1, 0);
      if (c >= 28) begin settle(); chk("gap_lock", int'(locked0), (c == 29) ? 1 : 0); end
    end
    for (int i = 0; i < 200; i++) send(0, 1'($urandom), 0);
    send(1, 1, 1);
    settle();
    chk("clr_err_pulse", int'(pulse0), 1);
    chk("clr_err_cnt", int'(cnt0), 0);

    // Saturation on the 2-bit counter instance.
    send(0, 1, 1);
    for (int e = 0; e < 5; e++) begin
      send(1, 1, 0);
      for (int i = 0; i < 12; i++) send(0, 1, 0);
    end
    settle();
    chk("sat_cnt1", int'(cnt1), 3);
    chk("sat_locked1", int'(locked1), 1);
    chk("sat_cnt0", int'(cnt0), 5);

    // Asynchronous reset mid-lock.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_locked0", int'(locked0), 0);
    chk("arst_pulse0",  int'(pulse0),  0);
    chk("arst_cnt0",    int'(cnt0),    0);
    chk("arst_locked1", int'(locked1), 0);
    chk("arst_cnt1",    int'(cnt1),    0);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    m_reset();

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
